ofdm_fft_sequencer: RTL and testbench



---
 rtl/ofdm_pkg.sv | 21 ++
 rtl/ofdm_bin_buffer.sv | 31 +++
 rtl/ofdm_fft_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ofdm_fft_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared types, constants and bin-slice helpers for the OFDM FFT sequencer
package ofdm_pkg;

   localparam int NUM_BINS = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2
   } seq_state_t;

   // Flat FFT bus layout: bin k occupies 2*W bits, real part in the low half.
   function automatic int bin_re_lo(input int k, input int w);
      return 2 * k * w;
   endfunction

   function automatic int bin_im_lo(input int k, input int w);
      return 2 * k * w + w;
   endfunction

endpackage

// File: rtl/ofdm_bin_buffer.sv
// rtl/ofdm_bin_buffer.sv - 16-entry re/im snapshot bank with parallel load and indexed read
module ofdm_bin_buffer
   import ofdm_pkg::*;
#(
   parameter int WORD_SIZE = 16
) (
   input  logic                              i_clk,
   input  logic                              i_load,
   input  logic [2*NUM_BINS*WORD_SIZE-1:0]   i_bins,
   input  logic [3:0]                        i_rd_idx,
   output logic [WORD_SIZE-1:0]              o_rd_re,
   output logic [WORD_SIZE-1:0]              o_rd_im
);

   // Contents are only meaningful after a load, so the bank carries no reset.
   logic [WORD_SIZE-1:0] r_re [NUM_BINS];
   logic [WORD_SIZE-1:0] r_im [NUM_BINS];

   always_ff @(posedge i_clk) begin
      if (i_load) begin
         for (int k = 0; k < NUM_BINS; k++) begin
            r_re[k] <= i_bins[bin_re_lo(k, WORD_SIZE) +: WORD_SIZE];
            r_im[k] <= i_bins[bin_im_lo(k, WORD_SIZE) +: WORD_SIZE];
         end
      end
   end

   assign o_rd_re = r_re[i_rd_idx];
   assign o_rd_im = r_im[i_rd_idx];

endmodule

// File: rtl/ofdm_fft_sequencer.sv
// rtl/ofdm_fft_sequencer.sv - sequences one byte per FFT symbol, captures 16 bins and streams them out
module ofdm_fft_sequencer
   import ofdm_pkg::*;
#(
   parameter int WORD_SIZE      = 16,
   parameter int DATA_LENGTH    = 8,
   parameter int DONE_SKIP      = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_byte_valid,
   input  logic [7:0]                        i_byte,
   output logic                              o_byte_ready,
   output logic [DATA_LENGTH:0]              o_fft_byte,
   input  logic                              i_fft_done,
   input  logic [32*WORD_SIZE-1:0]           i_fft_bins,
   output logic                              o_bin_valid,
   input  logic                              i_bin_ready,
   output logic [WORD_SIZE-1:0]              o_bin_re,
   output logic [WORD_SIZE-1:0]              o_bin_im,
   output logic [3:0]                        o_bin_idx,
   output logic                              o_bin_last,
   output logic [15:0]                       o_sym_count,
   output logic                              o_err
);

   localparam int BW  = DATA_LENGTH + 1;
   localparam int SKW = $clog2(DONE_SKIP + 2);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

   seq_state_t           r_state, w_next;
   logic                 r_byte_ready;
   logic [BW-1:0]        r_fft_byte;
   logic                 r_bin_valid;
   logic [WORD_SIZE-1:0] r_bin_re, r_bin_im;
   logic [3:0]           r_bin_idx;
   logic                 r_bin_last;
   logic [15:0]          r_sym_count;
   logic                 r_err;
   logic [SKW-1:0]       r_skip_cnt;
   logic [TW-1:0]        r_timer;

   logic                 w_accept, w_capture, w_timeout, w_hs, w_last_hs;
   logic [3:0]           w_rd_idx;
   logic [WORD_SIZE-1:0] w_rd_re, w_rd_im;

   // Read one entry ahead so the next beat can be registered on each handshake.
   assign w_rd_idx = r_bin_idx + 4'd1;

   ofdm_bin_buffer #(.WORD_SIZE(WORD_SIZE)) u_buf (
      .i_clk    (i_clk),
      .i_load   (w_capture),
      .i_bins   (i_fft_bins),
      .i_rd_idx (w_rd_idx),
      .o_rd_re  (w_rd_re),
      .o_rd_im  (w_rd_im)
   );

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_timeout = 1'b0;
      w_hs      = 1'b0;
      w_last_hs = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_byte_valid && r_byte_ready) begin
               w_accept = 1'b1;
               w_next   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A capture on the final timer cycle wins over the timeout.
            if (i_fft_done && (r_skip_cnt == '0)) begin
               w_capture = 1'b1;
               w_next    = ST_STREAM;
            end else if (r_timer == TIMER_MAX) begin
               w_timeout = 1'b1;
               w_next    = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (r_bin_valid && i_bin_ready) begin
               w_hs = 1'b1;
               if (r_bin_idx == 4'd15) begin
                  w_last_hs = 1'b1;
                  w_next    = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_byte_ready <= 1'b0;
         r_fft_byte   <= '0;
         r_bin_valid  <= 1'b0;
         r_bin_re     <= '0;
         r_bin_im     <= '0;
         r_bin_idx    <= '0;
         r_bin_last   <= 1'b0;
         r_sym_count  <= '0;
         r_err        <= 1'b0;
         r_skip_cnt   <= '0;
         r_timer      <= '0;
      end else begin
         r_state      <= w_next;
         r_byte_ready <= (w_next == ST_IDLE);

         if (w_accept) begin
            r_fft_byte <= BW'(i_byte);
            r_skip_cnt <= SKW'(DONE_SKIP);
            r_timer    <= '0;
         end

         if (r_state == ST_WAIT) begin
            if (w_capture) begin
               r_bin_valid <= 1'b1;
               r_bin_idx   <= '0;
               r_bin_last  <= 1'b0;
               r_bin_re    <= i_fft_bins[bin_re_lo(0, WORD_SIZE) +: WORD_SIZE];
               r_bin_im    <= i_fft_bins[bin_im_lo(0, WORD_SIZE) +: WORD_SIZE];
            end else if (w_timeout) begin
               r_err <= 1'b1;
            end else begin
               r_timer <= r_timer + TW'(1);
               if (i_fft_done) begin
                  r_skip_cnt <= r_skip_cnt - SKW'(1);
               end
            end
         end

         if (w_last_hs) begin
            r_bin_valid <= 1'b0;
            r_bin_idx   <= '0;
            r_bin_last  <= 1'b0;
            r_sym_count <= r_sym_count + 16'd1;
         end else if (w_hs) begin
            r_bin_idx  <= w_rd_idx;
            r_bin_last <= (w_rd_idx == 4'd15);
            r_bin_re   <= w_rd_re;
            r_bin_im   <= w_rd_im;
         end
      end
   end

   assign o_byte_ready = r_byte_ready;
   assign o_fft_byte   = r_fft_byte;
   assign o_bin_valid  = r_bin_valid;
   assign o_bin_re     = r_bin_re;
   assign o_bin_im     = r_bin_im;
   assign o_bin_idx    = r_bin_idx;
   assign o_bin_last   = r_bin_last;
   assign o_sym_count  = r_sym_count;
   assign o_err        = r_err;

endmodule

// File: tb/tb_ofdm_fft_sequencer.sv
// tb/tb_ofdm_fft_sequencer.sv - scoreboard bench for the OFDM FFT sequencer
module tb_ofdm_fft_sequencer;

   logic         clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_byte_valid = 1'b0;
   logic [7:0]   i_byte = 8'h00;
   logic         o_byte_ready;
   logic [8:0]   o_fft_byte;
   logic         i_fft_done = 1'b0;
   logic [511:0] i_fft_bins = '0;
   logic         o_bin_valid;
   logic         i_bin_ready = 1'b1;
   logic [15:0]  o_bin_re, o_bin_im;
   logic [3:0]   o_bin_idx;
   logic         o_bin_last;
   logic [15:0]  o_sym_count;
   logic         o_err;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic [3:0]  idx;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    failures = 0;

   ofdm_fft_sequencer dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_byte_valid (i_byte_valid),
      .i_byte       (i_byte),
      .o_byte_ready (o_byte_ready),
      .o_fft_byte   (o_fft_byte),
      .i_fft_done   (i_fft_done),
      .i_fft_bins   (i_fft_bins),
      .o_bin_valid  (o_bin_valid),
      .i_bin_ready  (i_bin_ready),
      .o_bin_re     (o_bin_re),
      .o_bin_im     (o_bin_im),
      .o_bin_idx    (o_bin_idx),
      .o_bin_last   (o_bin_last),
      .o_sym_count  (o_sym_count),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bin_re(input logic [3:0] seed, input int k);
      return {seed, 4'hA, 4'(k), 4'(15 - k)};
   endfunction

   function automatic logic [15:0] bin_im(input logic [3:0] seed, input int k);
      return {4'(k), seed, 8'h3C ^ 8'(k)};
   endfunction

   function automatic logic [511:0] make_bins(input logic [3:0] seed);
      logic [511:0] b;
      b = '0;
      for (int k = 0; k < 16; k++) begin
         b[32*k +: 16]      = bin_re(seed, k);
         b[32*k + 16 +: 16] = bin_im(seed, k);
      end
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_sym(input logic [3:0] seed);
      beat_t b;
      for (int k = 0; k < 16; k++) begin
         b.re   = bin_re(seed, k);
         b.im   = bin_im(seed, k);
         b.idx  = 4'(k);
         b.last = (k == 15);
         sb.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic done_same);
      int n;
      n = 0;
      i_byte       = b;
      i_byte_valid = 1'b1;
      i_fft_done   = done_same;
      while (!o_byte_ready && n < 200) begin
         tick();
         n++;
      end
      check("accept_ready_wait", {63'd0, o_byte_ready}, 64'd1);
      tick();
      i_byte_valid = 1'b0;
      i_fft_done   = 1'b0;
      check("accept_ready_low", {63'd0, o_byte_ready}, 64'd0);
      check("accept_fft_byte", {55'd0, o_fft_byte}, {56'd0, b});
   endtask

   task automatic do_done(input int n);
      repeat (n - 1) tick();
      i_fft_done = 1'b1;
      tick();
      i_fft_done = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every handshake and checks held beats stay stable.
   beat_t hold;
   logic  have_hold = 1'b0;
   always @(negedge clk) begin
      beat_t cur, exp;
      cur = '{re: o_bin_re, im: o_bin_im, idx: o_bin_idx, last: o_bin_last};
      if (i_rst || !o_bin_valid) begin
         have_hold = 1'b0;
      end else begin
         if (have_hold) check("beat_stable", 64'(cur), 64'(hold));
         if (i_bin_ready) begin
            have_hold = 1'b0;
            if (sb.size() == 0) begin
               check("unexpected_beat_idx", 64'(cur.idx), 64'hFFFF);
            end else begin
               exp = sb.pop_front();
               check("beat_re", 64'(cur.re), 64'(exp.re));
               check("beat_im", 64'(cur.im), 64'(exp.im));
               check("beat_idx", 64'(cur.idx), 64'(exp.idx));
               check("beat_last", 64'(cur.last), 64'(exp.last));
            end
         end else begin
            hold      = cur;
            have_hold = 1'b1;
         end
      end
   end

   initial begin
      int cyc;

      // Reset values
      repeat (2) tick();
      check("rst_ready", {63'd0, o_byte_ready}, 64'd0);
      check("rst_valid", {63'd0, o_bin_valid}, 64'd0);
      check("rst_sym", 64'(o_sym_count), 64'd0);
      check("rst_err", {63'd0, o_err}, 64'd0);
      check("rst_fft_byte", 64'(o_fft_byte), 64'd0);
      i_rst = 1'b0;
      check("rel_ready_before_edge", {63'd0, o_byte_ready}, 64'd0);
      tick();
      check("rel_ready_after_edge", {63'd0, o_byte_ready}, 64'd1);

      // Nominal: skip at T+5, capture at T+9
      i_fft_bins = make_bins(4'd1);
      send_byte(8'hB4, 1'b0);
      do_done(5);
      check("nom_skip_no_valid", {63'd0, o_bin_valid}, 64'd0);
      push_sym(4'd1);
      do_done(4);
      check("nom_cap_valid", {63'd0, o_bin_valid}, 64'd1);
      check("nom_cap_idx", 64'(o_bin_idx), 64'd0);
      i_byte       = 8'h55;
      i_byte_valid = 1'b1;
      repeat (15) tick();
      check("nom_idx15", 64'(o_bin_idx), 64'd15);
      check("nom_last15", {63'd0, o_bin_last}, 64'd1);
      check("nom_ready_streaming", {63'd0, o_byte_ready}, 64'd0);
      check("nom_byte_held", 64'(o_fft_byte), 64'h0B4);
      tick();
      check("nom_end_ready", {63'd0, o_byte_ready}, 64'd1);
      check("nom_end_valid", {63'd0, o_bin_valid}, 64'd0);
      check("nom_sym", 64'(o_sym_count), 64'd1);
      check("nom_byte_after", 64'(o_fft_byte), 64'h0B4);

      // Back-pressure and stale data
      send_byte(8'h55, 1'b0);
      i_bin_ready = 1'b0;
      i_fft_bins  = make_bins(4'd2);
      do_done(2);
      push_sym(4'd2);
      do_done(2);
      check("bp_cap_valid", {63'd0, o_bin_valid}, 64'd1);
      i_fft_bins = make_bins(4'd3);
      cyc = 0;
      while (!o_byte_ready && cyc < 100) begin
         tick();
         cyc++;
         i_bin_ready = ~i_bin_ready;
      end
      i_bin_ready = 1'b1;
      check("bp_stream_cycles", 64'(cyc), 64'd32);
      check("bp_sym", 64'(o_sym_count), 64'd2);

      // Timeout
      send_byte(8'h3C, 1'b0);
      repeat (63) tick();
      check("to_err_before", {63'd0, o_err}, 64'd0);
      check("to_ready_before", {63'd0, o_byte_ready}, 64'd0);
      tick();
      check("to_err", {63'd0, o_err}, 64'd1);
      check("to_ready", {63'd0, o_byte_ready}, 64'd1);
      check("to_sym", 64'(o_sym_count), 64'd2);

      // Done in accept cycle and during STREAM are ignored
      i_fft_bins = make_bins(4'd4);
      send_byte(8'hE7, 1'b1);
      do_done(3);
      check("edge_skip_no_valid", {63'd0, o_bin_valid}, 64'd0);
      push_sym(4'd4);
      do_done(3);
      check("edge_cap_valid", {63'd0, o_bin_valid}, 64'd1);
      repeat (4) tick();
      do_done(1);
      cyc = 0;
      while (!o_byte_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      check("edge_stream_rest", 64'(cyc), 64'd11);
      check("edge_sym", 64'(o_sym_count), 64'd3);
      check("edge_err_sticky", {63'd0, o_err}, 64'd1);
      check("edge_sb_empty", 64'(sb.size()), 64'd0);

      // Reset mid-STREAM at idx 7
      i_fft_bins = make_bins(4'd5);
      send_byte(8'h99, 1'b0);
      do_done(1);
      push_sym(4'd5);
      do_done(1);
      repeat (7) tick();
      check("mid_idx7", 64'(o_bin_idx), 64'd7);
      i_rst = 1'b1;
      #1;
      check("mid_rst_valid", {63'd0, o_bin_valid}, 64'd0);
      check("mid_rst_idx", 64'(o_bin_idx), 64'd0);
      check("mid_rst_last", {63'd0, o_bin_last}, 64'd0);
      check("mid_rst_re", 64'(o_bin_re), 64'd0);
      check("mid_rst_im", 64'(o_bin_im), 64'd0);
      check("mid_rst_sym", 64'(o_sym_count), 64'd0);
      check("mid_rst_err", {63'd0, o_err}, 64'd0);
      check("mid_rst_byte", 64'(o_fft_byte), 64'd0);
      check("mid_rst_ready", {63'd0, o_byte_ready}, 64'd0);
      sb.delete();
      tick();
      i_rst = 1'b0;
      check("mid_rel_ready_low", {63'd0, o_byte_ready}, 64'd0);
      tick();
      check("mid_rel_ready", {63'd0, o_byte_ready}, 64'd1);
      check("mid_rel_valid", {63'd0, o_bin_valid}, 64'd0);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
